// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - parametrised single-port RAM command engine behind an SPI slave
//
// Decodes {cmd[1:0], payload[PW-1:0]} words presented with rx_valid and
// keeps independent write/read pointers into a MEMDEPTH x MEMWIDTH RAM.
//   cmd 00 SET_WADDR  wr_ptr <= payload
//   cmd 01 WRITE      mem[wr_ptr] <= payload (optional post-increment)
//   cmd 10 SET_RADDR  rd_ptr <= payload
//   cmd 11 READ       dout <= mem[rd_ptr], one-cycle tx_valid (optional post-increment)
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (RAM contents are not cleared)
//   rx_valid  din carries a complete command word this cycle
//   din       [PW+1:PW] command, [PW-1:0] payload
//   tx_valid  one-cycle pulse per READ, dout valid
//   dout      read data, held between reads
//   addr_err  sticky flag, set by any WRITE/READ at an address >= MEMDEPTH
module spi_ram_ctrl #(
    parameter int MEMDEPTH  = 256,
    parameter int MEMWIDTH  = 8,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 1,
    localparam int PW = (MEMWIDTH > ADDR_SIZE) ? MEMWIDTH : ADDR_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [PW+1:0]       din,
    output logic                tx_valid,
    output logic [MEMWIDTH-1:0] dout,
    output logic                addr_err
);

    // Index width into the RAM array; accesses are range-guarded first,
    // so the low bits of the pointer are sufficient.
    localparam int AW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
    localparam logic [ADDR_SIZE:0]   DEPTH_W = (ADDR_SIZE+1)'(MEMDEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEMDEPTH - 1);

    localparam logic [1:0] CMD_SET_WADDR = 2'b00;
    localparam logic [1:0] CMD_WRITE     = 2'b01;
    localparam logic [1:0] CMD_SET_RADDR = 2'b10;
    localparam logic [1:0] CMD_READ      = 2'b11;

    logic [MEMWIDTH-1:0]  mem [0:MEMDEPTH-1];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;

    logic [1:0] cmd;
    logic       wr_in_range;
    logic       rd_in_range;

    assign cmd         = din[PW+1:PW];
    assign wr_in_range = ({1'b0, wr_ptr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_ptr} < DEPTH_W);

    // Wraps at the last valid word; a pointer already out of range simply
    // counts on modulo 2**ADDR_SIZE.
    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    // RAM array has no reset so its contents survive rst_n; a write is
    // still suppressed while reset is asserted because reset wins.
    always_ff @(posedge clk) begin
        if (rst_n && rx_valid && (cmd == CMD_WRITE) && wr_in_range) begin
            mem[wr_ptr[AW-1:0]] <= din[MEMWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_SET_WADDR: wr_ptr <= din[ADDR_SIZE-1:0];
                    CMD_WRITE: begin
                        if (!wr_in_range) begin
                            addr_err <= 1'b1;
                        end
                        if (AUTO_INC != 0) begin
                            wr_ptr <= next_ptr(wr_ptr);
                        end
                    end
                    CMD_SET_RADDR: rd_ptr <= din[ADDR_SIZE-1:0];
                    CMD_READ: begin
                        tx_valid <= 1'b1;
                        if (rd_in_range) begin
                            dout <= mem[rd_ptr[AW-1:0]];
                        end else begin
                            dout     <= '0;
                            addr_err <= 1'b1;
                        end
                        if (AUTO_INC != 0) begin
                            rd_ptr <= next_ptr(rd_ptr);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
